// File: rtl/lfsr_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Desc     : Shared types and reset defaults for the LFSR sharing controller.
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  localparam int LFSR_W = 5;

  // x^5 + x^3 + 1, and a nonzero starting state
  localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 5'b10100;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 5'b00001;

  typedef enum logic [1:0] {
    SEED = 2'd0,
    IDLE = 2'd1,
    GEN  = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lfsr_share_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Desc     : Round-robin arbiter. Grants the first requester at or after the
//            pointer (wrapping), and moves the pointer past the winner when a
//            grant is actually issued.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             hi_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Pick lowest set index >= pointer, else lowest set index overall
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    grant     = '0;
    ptr_d     = ptr_q;
    if (enable && (|req)) begin
      grant[grant_idx] = 1'b1;
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lfsr_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_share_ctrl
// Desc     : Shares one LFSR among NUM_REQ requesters. Each granted request
//            advances the LFSR WORD_W times, collects the serial output LSB
//            first and returns the word tagged with the requester id.
//            Optional build macro LFSR_ZERO_GUARD_EN: a zero LFSR state seen
//            while generating reseeds the LFSR and sets sticky zero_lock_err.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_share_ctrl #(
  parameter int                             NUM_REQ      = 4,
  parameter int                             WORD_W       = 8,
  parameter int                             LFSR_W       = lfsr_pkg::LFSR_W,
  parameter logic [lfsr_pkg::LFSR_W-1:0]    DEFAULT_TAPS = lfsr_pkg::DEFAULT_TAPS,
  parameter logic [lfsr_pkg::LFSR_W-1:0]    DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED,
  parameter int                             ID_W         = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_grant,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [WORD_W-1:0]  rsp_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [LFSR_W-1:0]  cfg_seed,
  input  logic [LFSR_W-1:0]  cfg_taps,
  output logic               lfsr_reinit,
  output logic               lfsr_advance,
  output logic [LFSR_W-1:0]  lfsr_init_state,
  output logic [LFSR_W-1:0]  lfsr_taps,
  input  logic               lfsr_out,
  input  logic [LFSR_W-1:0]  lfsr_state
`ifdef LFSR_ZERO_GUARD_EN
  ,
  output logic               zero_lock_err
`endif
);

  import lfsr_pkg::*;

  localparam int CNT_W = $clog2(WORD_W) + 1;

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  seed_q, seed_d;
  logic [LFSR_W-1:0]  taps_q, taps_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               zero_err_q, zero_err_d;

  logic               arb_en;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .enable    (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

`ifdef LFSR_ZERO_GUARD_EN
  assign zero_lock_err = zero_err_q;
`else
  // State is only inspected by the zero guard
  logic unused_state;
  assign unused_state = ^{lfsr_state, zero_err_q};
`endif

  assign lfsr_init_state = seed_q;
  assign lfsr_taps       = taps_q;
  assign rsp_data        = data_q;
  assign rsp_id          = id_q;
  assign req_grant       = arb_grant;

  // Next-state and output decode for the sequencer
  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    taps_d       = taps_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    zero_err_d   = zero_err_q;
    arb_en       = 1'b0;
    cfg_ready    = 1'b0;
    rsp_valid    = 1'b0;
    lfsr_reinit  = 1'b0;
    lfsr_advance = 1'b0;
    case (state_q)
      SEED: begin
        lfsr_reinit = 1'b1;
        state_d     = IDLE;
      end
      IDLE: begin
        if (cfg_valid) begin
          // A zero seed would lock the LFSR, so it is promoted to 1
          cfg_ready = 1'b1;
          seed_d    = (cfg_seed == '0) ? LFSR_W'(1) : cfg_seed;
          taps_d    = cfg_taps;
          state_d   = SEED;
        end else if (|req_valid) begin
          arb_en  = 1'b1;
          id_d    = arb_idx;
          cnt_d   = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        lfsr_advance   = 1'b1;
        data_d[cnt_q]  = lfsr_out;
`ifdef LFSR_ZERO_GUARD_EN
        if (lfsr_state == '0) begin
          lfsr_advance  = 1'b0;
          lfsr_reinit   = 1'b1;
          data_d[cnt_q] = 1'b0;
          zero_err_d    = 1'b1;
        end
`endif
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WORD_W - 1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = SEED;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEED;
      seed_q     <= DEFAULT_SEED;
      taps_q     <= DEFAULT_TAPS;
      id_q       <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      taps_q     <= taps_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      zero_err_q <= zero_err_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/lfsr_share_ctrl.md
Name: lfsr_share_ctrl

Overview:
- Sequencer and round-robin arbiter that shares one lfsr instance among NUM_REQ requesters.
- Owns the LFSR's seed and taps configuration.
- Per granted request, advances the LFSR WORD_W times, collects the serial `out` bit into a word, and returns it on a single response channel tagged with the requester id.
- Sits between the lfsr datapath and clients needing pseudo-random words (scramblers, test-pattern sources).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_W, 8, bits per response word (1..32).
- LFSR_W, 5, LFSR state/taps width.
- DEFAULT_TAPS, 5'b10100, taps loaded at reset (x^5+x^3+1).
- DEFAULT_SEED, 5'b00001, seed loaded at reset; must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester word request (level).
- req_grant  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
- rsp_valid  out  1  response word valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  requester index of the response.
- rsp_data  out  WORD_W  collected word.
- cfg_valid  in  1  new seed/taps offered.
- cfg_ready  out  1  config accepted this cycle.
- cfg_seed  in  LFSR_W  new seed.
- cfg_taps  in  LFSR_W  new taps.
- lfsr_reinit  out  1  to lfsr.reinit.
- lfsr_advance  out  1  to lfsr.advance.
- lfsr_init_state  out  LFSR_W  to lfsr.initial_state (= seed register).
- lfsr_taps  out  LFSR_W  to lfsr.taps (= taps register).
- lfsr_out  in  1  from lfsr.out.
- lfsr_state  in  LFSR_W  from lfsr.out_state.

Behaviour:
- Reset values:
  - FSM = SEED.
  - seed_q = DEFAULT_SEED; taps_q = DEFAULT_TAPS.
  - rr pointer = 0; bit counter = 0; data shift register = 0.
  - All outputs 0 except lfsr_init_state/lfsr_taps, which reflect the registers.
- lfsr_taps and lfsr_init_state are driven continuously from taps_q/seed_q.
- FSM states: SEED, IDLE, GEN, RESP.
- SEED:
  - lfsr_reinit=1 for exactly one cycle, then IDLE.
- IDLE, evaluated in priority order:
  1. If cfg_valid: cfg_ready=1 that cycle, seed_q<=cfg_seed (cfg_seed==0 is stored as 1), taps_q<=cfg_taps, next state SEED. Config always beats pending requests.
  2. Else if any req_valid: grant the first set bit at or after the rr pointer (wrapping NUM_REQ-1 -> 0). Pulse req_grant[i], latch id=i, rr pointer <= i+1 mod NUM_REQ, counter <= 0, next state GEN.
  3. Else stay in IDLE.
- GEN:
  - lfsr_advance=1 every cycle for exactly WORD_W cycles.
  - Each cycle captures lfsr_out (pre-shift value) into data bit[counter]; LSB first.
  - After the WORD_W-th cycle: next state RESP, lfsr_advance drops.
  - Requests and config arriving during GEN are held off (no grant, cfg_ready=0).
- RESP:
  - rsp_valid=1; rsp_data/rsp_id are stable until rsp_ready.
  - The cycle rsp_valid & rsp_ready is seen, return to IDLE.
  - rsp_valid deasserts the next cycle.
  - No new grant in the handshake cycle.
- Throughput and latency:
  - Grant-to-rsp_valid latency = WORD_W+1 cycles.
  - Minimum per-word period = WORD_W+2 cycles.
- LFSR state persists across requests; consecutive words continue the same sequence.
- rst in any state: abort, discard the partial word, re-enter SEED with default seed/taps. A pending rsp_valid is dropped.
- req_valid is level-sensitive; dropping it before grant simply forfeits. It is never queued.
- lfsr_reinit and lfsr_advance are never both 1.

Optional Feature:
- Macro LFSR_ZERO_GUARD_EN.
- When defined:
  - In GEN, if lfsr_state==0 is seen, that cycle issues lfsr_reinit instead of advance.
  - The captured bit is 0; counter still increments.
  - A sticky output zero_lock_err (1 bit, reset 0, cleared only by rst) is set.
- When undefined:
  - No check; a zero state is propagated.
  - The zero_lock_err port is absent.

Decomposition:
- Package lfsr_pkg:
  - typedef enum for FSM states {SEED, IDLE, GEN, RESP}.
  - LFSR_W constant.
  - DEFAULT_TAPS/DEFAULT_SEED defaults.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs req, enable; outputs one-hot grant, grant index.
  - Internal pointer update on enable&|req.

Test Plan:
- Reset then single req_valid[0], rsp_ready=1, default seed/taps, golden model (new bit0 = XOR(taps&state), state shifts up):
  - req_grant=4'b0001 one cycle after leaving SEED.
  - rsp_valid 9 cycles after grant.
  - rsp_data=8'h69, rsp_id=0.
- req_valid=4'b1111 held for four words:
  - Grants in order 0,1,2,3.
  - Words match consecutive 8-bit slices of the model sequence.
  - 10 cycles between grants with rsp_ready=1.
- rsp_ready held 0 for 5 cycles in RESP:
  - rsp_valid/rsp_data/rsp_id stable for those cycles.
  - No grant until one cycle after the handshake.
- cfg_valid with seed=0, taps=5'b10010 while req_valid[2]=1 in IDLE:
  - cfg_ready wins; seed_q reads 1.
  - Exactly one lfsr_reinit pulse, then grant to requester 2.
- rst asserted at the 4th GEN cycle:
  - Next cycle: rsp_valid=0, lfsr_reinit=1, lfsr_init_state=5'b00001, taps=5'b10100.
  - No response for the aborted request.
- LFSR_ZERO_GUARD_EN defined, bench forces lfsr_state=0 during GEN:
  - lfsr_reinit replaces advance that cycle; zero_lock_err=1 until rst.
